// File: rtl/scard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scard_pkg
// Brief   : Shared types and constants for the smartcard receive capture block
// Revision: 1.0
// ============================================================================
package scard_pkg;

   localparam int BYTE_W           = 8;
   localparam int SCARD_DEPTH_LOG2 = 5;
   localparam int DEPTH            = 2**SCARD_DEPTH_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FIRST = 2'd1,
      ST_RECEIVING  = 2'd2,
      ST_DONE       = 2'd3
   } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/scard_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : scard_rx_fifo
// Brief   : Single-clock byte FIFO with flush, occupancy count, registered read
// Revision: 1.0
// ============================================================================
module scard_rx_fifo
   import scard_pkg::*;
#(
   parameter int DEPTH_LOG2 = SCARD_DEPTH_LOG2
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  flush,
   input  logic                  push,
   input  logic [BYTE_W-1:0]     push_data,
   input  logic                  pop,
   output logic                  push_ok,
   output logic [BYTE_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int                 c_depth    = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_full_cnt = (DEPTH_LOG2+1)'(c_depth);

   logic [BYTE_W-1:0]     r_mem [c_depth];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [BYTE_W-1:0]     r_rd_data;
   logic                  r_rd_valid;
   logic                  w_pop_ok;
   logic                  w_push_ok;

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push then
   assign w_pop_ok  = pop && (r_count != '0) && !flush;
   assign w_push_ok = push && !flush && ((r_count != c_full_cnt) || w_pop_ok);

   always_ff @(posedge clk_i) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop_ok;
         if (w_pop_ok) begin
            r_rd_data <= r_mem[r_rd_ptr];
         end
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign push_ok  = w_push_ok;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/scard_rx_capture.sv
`default_nettype none
// ============================================================================
// Module  : scard_rx_capture
// Brief   : Captures a burst of smartcard bytes, delimited by an idle timeout
// Revision: 1.0
// ============================================================================
module scard_rx_capture
   import scard_pkg::*;
#(
   parameter int DEPTH_LOG2 = SCARD_DEPTH_LOG2,
   parameter int TMO_W      = 24,
   parameter int CNT_W      = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic [BYTE_W-1:0]     rx_data,
   input  logic                  rx_datardy,
   input  logic                  arm,
   input  logic                  clear,
   input  logic [TMO_W-1:0]      idle_timeout,
   input  logic                  rd_en,
   output logic [BYTE_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic [CNT_W-1:0]      rx_total,
   output logic                  overflow,
   output logic                  busy,
   output logic                  done,
   output logic                  done_pulse
);

   cap_state_t         r_state;
   cap_state_t         w_state_nxt;
   logic [TMO_W-1:0]   r_timer;
   logic [CNT_W-1:0]   r_rx_total;
   logic               r_overflow;
   logic               r_done_pulse;
   logic               w_flush;
   logic               w_capturing;
   logic               w_rx_take;
   logic               w_push_ok;
   logic               w_timeout;

   assign w_flush     = arm | clear;
   assign w_capturing = (r_state == ST_WAIT_FIRST) || (r_state == ST_RECEIVING);
   assign w_rx_take   = rx_datardy && !w_flush && w_capturing;
   // A byte landing on the expiry cycle keeps the burst alive
   assign w_timeout   = (r_state == ST_RECEIVING) && !rx_datardy &&
                        (idle_timeout != '0) && (r_timer == idle_timeout - 1'b1);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_IDLE;
      end else if (arm) begin
         w_state_nxt = ST_WAIT_FIRST;
      end else begin
         case (r_state)
            ST_WAIT_FIRST: if (rx_datardy) w_state_nxt = ST_RECEIVING;
            ST_RECEIVING:  if (w_timeout)  w_state_nxt = ST_DONE;
            default:       w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_timer      <= '0;
         r_rx_total   <= '0;
         r_overflow   <= 1'b0;
         r_done_pulse <= 1'b0;
      end else begin
         r_done_pulse <= (r_state == ST_RECEIVING) && (w_state_nxt == ST_DONE);
         if (w_flush) begin
            r_timer    <= '0;
            r_rx_total <= '0;
            r_overflow <= 1'b0;
         end else if (w_rx_take) begin
            r_timer <= '0;
            if (r_rx_total != '1) r_rx_total <= r_rx_total + 1'b1;
            if (!w_push_ok)       r_overflow <= 1'b1;
         end else if ((r_state == ST_RECEIVING) && (r_timer != '1)) begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   scard_rx_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .flush     (w_flush),
      .push      (w_rx_take),
      .push_data (rx_data),
      .pop       (rd_en),
      .push_ok   (w_push_ok),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .count     (fifo_count)
   );

   assign rx_total   = r_rx_total;
   assign overflow   = r_overflow;
   assign busy       = w_capturing;
   assign done       = (r_state == ST_DONE);
   assign done_pulse = r_done_pulse;

endmodule
`default_nettype wire

// File: tb/tb_scard_rx_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_scard_rx_capture
// Brief   : Self-checking bench: vector table, directed corners, random vs model
// Revision: 1.0
// ============================================================================
module tb_scard_rx_capture;

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_RECV = 2;
   localparam int M_DONE = 3;
   localparam int M_CAP  = 32;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_datardy = 1'b0;
   logic        arm = 1'b0;
   logic        clear = 1'b0;
   logic [23:0] idle_timeout = '0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [5:0]  fifo_count;
   logic [7:0]  rx_total;
   logic        overflow;
   logic        busy;
   logic        done;
   logic        done_pulse;

   scard_rx_capture dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .rx_data      (rx_data),
      .rx_datardy   (rx_datardy),
      .arm          (arm),
      .clear        (clear),
      .idle_timeout (idle_timeout),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .fifo_count   (fifo_count),
      .rx_total     (rx_total),
      .overflow     (overflow),
      .busy         (busy),
      .done         (done),
      .done_pulse   (done_pulse)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Behavioural reference: a byte queue plus "idle cycles since last byte"
   logic [7:0] mq[$];
   int         m_state, m_idle, m_total;
   bit         m_ovf, m_rdv, m_pulse;
   logic [7:0] m_rdd;

   typedef struct {
      int arm, clear, rx, data, rd;
      int e_cnt, e_tot, e_busy, e_done, e_pulse, e_rdv, e_rdd;
   } vec_t;
   vec_t tbl[18];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task model_reset();
      mq.delete();
      m_state = M_IDLE; m_idle = 0; m_total = 0;
      m_ovf = 0; m_rdv = 0; m_pulse = 0; m_rdd = '0;
   endtask

   task model_update();
      bit flush, pop, take;
      flush = arm || clear;
      pop   = rd_en && (mq.size() > 0) && !flush;
      take  = rx_datardy && !flush && (m_state == M_WAIT || m_state == M_RECV);
      m_pulse = 0;
      m_rdv   = pop;
      if (pop) m_rdd = mq.pop_front();
      if (flush) begin
         mq.delete();
         m_total = 0;
         m_ovf   = 0;
         m_idle  = 0;
         m_state = clear ? M_IDLE : M_WAIT;
      end else if (take) begin
         if (mq.size() < M_CAP) mq.push_back(rx_data);
         else m_ovf = 1;
         if (m_total < 255) m_total++;
         m_idle  = 0;
         m_state = M_RECV;
      end else if (m_state == M_RECV) begin
         m_idle++;
         if (idle_timeout != 0 && m_idle == int'(idle_timeout)) begin
            m_state = M_DONE;
            m_pulse = 1;
         end
      end
   endtask

   task compare_model();
      chk("count",    fifo_count, mq.size());
      chk("total",    rx_total,   m_total);
      chk("overflow", overflow,   m_ovf);
      chk("busy",     busy,       (m_state == M_WAIT || m_state == M_RECV));
      chk("done",     done,       (m_state == M_DONE));
      chk("pulse",    done_pulse, m_pulse);
      chk("rd_valid", rd_valid,   m_rdv);
      chk("rd_data",  rd_data,    m_rdd);
   endtask

   task step();
      model_update();
      @(posedge clk_i);
      #1;
      compare_model();
   endtask

   task idle_inputs();
      arm = 0; clear = 0; rx_datardy = 0; rd_en = 0;
   endtask

   task send_byte(input logic [7:0] b);
      rx_data = b; rx_datardy = 1;
      step();
      rx_datardy = 0;
   endtask

   task do_arm();
      arm = 1;
      step();
      arm = 0;
   endtask

   initial begin
      int lat;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      compare_model();
      reset_n_i = 1;

      // ---------------- vector table, idle_timeout = 3 ----------------
      //            arm clr rx data rd  cnt tot bsy dn pls rdv rdd(-1 skip)
      tbl[0]  = '{0, 0, 1, 'h11, 0,  0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0,    0,  0, 0, 1, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 1, 'hA1, 0,  1, 1, 1, 0, 0, 0, 0};
      tbl[3]  = '{0, 0, 1, 'hA2, 0,  2, 2, 1, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 0,    0,  2, 2, 1, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 0, 0,    0,  2, 2, 1, 0, 0, 0, 0};
      tbl[6]  = '{0, 0, 1, 'hA3, 0,  3, 3, 1, 0, 0, 0, 0};
      tbl[7]  = '{0, 0, 0, 0,    0,  3, 3, 1, 0, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 0,    0,  3, 3, 1, 0, 0, 0, 0};
      tbl[9]  = '{0, 0, 0, 0,    0,  3, 3, 0, 1, 1, 0, 0};
      tbl[10] = '{0, 0, 1, 'h55, 0,  3, 3, 0, 1, 0, 0, 0};
      tbl[11] = '{0, 0, 0, 0,    1,  2, 3, 0, 1, 0, 1, 'hA1};
      tbl[12] = '{0, 0, 0, 0,    1,  1, 3, 0, 1, 0, 1, 'hA2};
      tbl[13] = '{1, 0, 0, 0,    1,  0, 0, 1, 0, 0, 0, 'hA2};
      tbl[14] = '{0, 0, 0, 0,    1,  0, 0, 1, 0, 0, 0, 'hA2};
      tbl[15] = '{0, 0, 1, 'h77, 0,  1, 1, 1, 0, 0, 0, -1};
      tbl[16] = '{1, 1, 0, 0,    0,  0, 0, 0, 0, 0, 0, -1};
      tbl[17] = '{0, 0, 1, 'h88, 0,  0, 0, 0, 0, 0, 0, -1};
      idle_timeout = 3;
      for (int i = 0; i < 18; i++) begin
         arm = tbl[i].arm[0]; clear = tbl[i].clear[0];
         rx_datardy = tbl[i].rx[0]; rx_data = tbl[i].data[7:0]; rd_en = tbl[i].rd[0];
         step();
         chk("tbl_cnt",   fifo_count, tbl[i].e_cnt);
         chk("tbl_total", rx_total,   tbl[i].e_tot);
         chk("tbl_busy",  busy,       tbl[i].e_busy);
         chk("tbl_done",  done,       tbl[i].e_done);
         chk("tbl_pulse", done_pulse, tbl[i].e_pulse);
         chk("tbl_rdv",   rd_valid,   tbl[i].e_rdv);
         if (tbl[i].e_rdd >= 0) chk("tbl_rdd", rd_data, tbl[i].e_rdd);
      end
      idle_inputs();

      // ---------------- ATR-style burst, timeout latency ----------------
      idle_timeout = 100;
      do_arm();
      send_byte(8'h3B); repeat (19) step();
      send_byte(8'h95); repeat (19) step();
      send_byte(8'h11);
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         step();
         if (done_pulse) begin lat = n; break; end
      end
      chk("tmo_latency", lat, 100);
      chk("burst_cnt", fifo_count, 3);
      chk("burst_total", rx_total, 3);
      rd_en = 1; step(); rd_en = 0;
      chk("rd0_valid", rd_valid, 1); chk("rd0_data", rd_data, 'h3B);
      rd_en = 1; step(); rd_en = 0;
      chk("rd1_valid", rd_valid, 1); chk("rd1_data", rd_data, 'h95);
      rd_en = 1; step(); rd_en = 0;
      chk("rd2_valid", rd_valid, 1); chk("rd2_data", rd_data, 'h11);
      step();
      chk("rd_valid_drop", rd_valid, 0);

      // ---------------- overflow with 40 back-to-back bytes ----------------
      idle_timeout = 50;
      do_arm();
      for (int i = 0; i < 40; i++) send_byte(8'h40 + 8'(i));
      chk("ovf_cnt", fifo_count, 32);
      chk("ovf_total", rx_total, 40);
      chk("ovf_flag", overflow, 1);
      rd_en = 1;
      for (int i = 0; i < 32; i++) begin
         step();
         chk("ovf_order", rd_data, 'h40 + i);
      end
      rd_en = 0; step();

      // ---------------- full buffer, simultaneous pop and push ----------------
      do_arm();
      for (int i = 0; i < 32; i++) send_byte(8'h80 + 8'(i));
      rd_en = 1; rx_datardy = 1; rx_data = 8'hAA;
      step();
      rx_datardy = 0;
      chk("full_rw_cnt", fifo_count, 32);
      chk("full_rw_ovf", overflow, 0);
      chk("full_rw_data", rd_data, 'h80);
      for (int i = 0; i < 32; i++) step();
      chk("full_rw_last", rd_data, 'hAA);
      rd_en = 0; step();

      // ---------------- clear+arm together, then async reset ----------------
      do_arm();
      for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
      arm = 1; clear = 1; step(); arm = 0; clear = 0;
      chk("clr_busy", busy, 0);
      chk("clr_cnt", fifo_count, 0);
      chk("clr_total", rx_total, 0);
      send_byte(8'h99);
      chk("clr_ignored", rx_total, 0);
      do_arm();
      for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
      rd_en = 1; step(); rd_en = 0;
      #3 reset_n_i = 0;
      #1;
      model_reset();
      chk("arst_cnt", fifo_count, 0);
      chk("arst_total", rx_total, 0);
      chk("arst_busy", busy, 0);
      chk("arst_rdv", rd_valid, 0);
      chk("arst_rdd", rd_data, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_done", done | done_pulse, 0);
      @(posedge clk_i); #1;
      reset_n_i = 1;

      // ---------------- idle_timeout = 0 never ends the burst ----------------
      idle_timeout = 0;
      do_arm();
      send_byte(8'h01); send_byte(8'h02);
      repeat (300) step();
      chk("notmo_busy", busy, 1);
      chk("notmo_done", done, 0);

      // ---------------- randomized phases against the model ----------------
      for (int ph = 0; ph < 12; ph++) begin
         int p_rx, p_rd;
         idle_timeout = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 8));
         p_rx = $urandom_range(20, 90);
         p_rd = $urandom_range(0, 60);
         arm = 1; step(); arm = 0;
         for (int c = 0; c < 400; c++) begin
            arm        = ($urandom_range(0, 99) < 2);
            clear      = ($urandom_range(0, 199) < 1);
            rx_datardy = ($urandom_range(0, 99) < p_rx);
            rx_data    = 8'($urandom);
            rd_en      = ($urandom_range(0, 99) < p_rd);
            step();
         end
         idle_inputs();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
